// File: rtl/multi_packet_integrity_sb.sv
// ---------------------------------------------------------------------------
// multi_packet_integrity_sb
//
// Data-integrity scoreboard bound alongside an in-order buffer (FIFO-class
// block with first-word-fall-through head data). It mirrors the buffer
// occupancy from the push/pop strobes and follows up to NSLOT marked
// packets through the buffer. When a marked packet leaves the buffer, the
// head data is compared against the value captured at push time. One
// registered pass/fail result is then produced. Illegal push/pop strobes
// are flagged as protocol errors.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   push       buffer write strobe
//   pop        buffer read strobe
//   start      mark the packet pushed this cycle for tracking
//   data_in    buffer write data
//   data_out   buffer head data, meaningful while pop is high
//   chk_vld    pulse: a tracked packet exited on the previous edge
//   chk_pass   with chk_vld: exiting data matched the captured data
//   mismatch   pulse: chk_vld & ~chk_pass
//   err        sticky: any mismatch since reset
//   proto_err  sticky: push when full or pop when empty since reset
//   drop       pulse: a start packet was accepted but no slot was free
//   occ        modelled buffer occupancy (0..DEPTH)
//   busy       number of slots currently tracking a packet
// ---------------------------------------------------------------------------
module multi_packet_integrity_sb #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int NSLOT  = 4,
   parameter int CNTWID = $clog2(DEPTH + 1),
   parameter int SLOTW  = $clog2(NSLOT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              start,
   input  logic [WIDTH-1:0]  data_in,
   input  logic [WIDTH-1:0]  data_out,
   output logic              chk_vld,
   output logic              chk_pass,
   output logic              mismatch,
   output logic              err,
   output logic              proto_err,
   output logic              drop,
   output logic [CNTWID-1:0] occ,
   output logic [SLOTW-1:0]  busy
);

   // Per-slot tracking state. pos counts from the buffer head (1 = head),
   // so a slot is checked exactly when a pop happens while its pos is 1.
   logic [NSLOT-1:0]  slot_vld;
   logic [WIDTH-1:0]  slot_data [NSLOT];
   logic [CNTWID-1:0] slot_pos  [NSLOT];

   logic              push_ok;
   logic              pop_ok;
   logic              capture;
   logic [CNTWID-1:0] occ_next;

   logic [NSLOT-1:0]  retire;
   logic              head_hit;
   logic [WIDTH-1:0]  head_data;

   logic [NSLOT-1:0]  alloc;
   logic              alloc_found;
   logic              drop_next;

   logic [NSLOT-1:0]  vld_next;
   logic [WIDTH-1:0]  data_next [NSLOT];
   logic [CNTWID-1:0] pos_next  [NSLOT];
   logic [SLOTW-1:0]  busy_next;

   // Strobe legality and the occupancy update. A push into a full buffer is
   // refused even when a pop happens in the same cycle, because the buffer
   // itself sees the push before the pop frees a word.
   always_comb begin
      push_ok  = push && (occ < CNTWID'(DEPTH));
      pop_ok   = pop && (occ != '0);
      capture  = push_ok && start;
      occ_next = occ + CNTWID'(push_ok) - CNTWID'(pop_ok);
   end

   // Find the slot sitting at the buffer head on a pop. The pos invariant
   // guarantees at most one such slot, so the OR-style mux is safe.
   always_comb begin
      retire    = '0;
      head_data = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (pop_ok && slot_vld[i] && (slot_pos[i] == CNTWID'(1))) begin
            retire[i] = 1'b1;
            head_data = slot_data[i];
         end
      end
      head_hit = |retire;
   end

   // Lowest-index allocation among slots that are empty or being retired
   // this very cycle, so a retiring slot can be reused immediately.
   always_comb begin
      alloc       = '0;
      alloc_found = 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
         if (capture && !alloc_found && (!slot_vld[i] || retire[i])) begin
            alloc[i]    = 1'b1;
            alloc_found = 1'b1;
         end
      end
      drop_next = capture && !alloc_found;
   end

   // Next slot contents. Allocation takes priority over retirement since a
   // reused slot must hold the new packet. Surviving slots step one place
   // closer to the head on every accepted pop. A new packet lands at
   // occ_next, which is the tail after this cycle's pop.
   always_comb begin
      busy_next = '0;
      for (int i = 0; i < NSLOT; i++) begin
         vld_next[i]  = slot_vld[i];
         data_next[i] = slot_data[i];
         pos_next[i]  = slot_pos[i];
         if (alloc[i]) begin
            vld_next[i]  = 1'b1;
            data_next[i] = data_in;
            pos_next[i]  = occ_next;
         end else if (retire[i]) begin
            vld_next[i] = 1'b0;
         end else if (pop_ok && slot_vld[i]) begin
            pos_next[i] = slot_pos[i] - CNTWID'(1);
         end
         if (vld_next[i]) begin
            busy_next = busy_next + SLOTW'(1);
         end
      end
   end

   // State registers and registered check outputs. Reset discards every
   // tracked packet without producing check pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ       <= '0;
         slot_vld  <= '0;
         chk_vld   <= 1'b0;
         chk_pass  <= 1'b0;
         mismatch  <= 1'b0;
         err       <= 1'b0;
         proto_err <= 1'b0;
         drop      <= 1'b0;
         busy      <= '0;
         for (int i = 0; i < NSLOT; i++) begin
            slot_data[i] <= '0;
            slot_pos[i]  <= '0;
         end
      end else begin
         occ       <= occ_next;
         slot_vld  <= vld_next;
         chk_vld   <= head_hit;
         chk_pass  <= head_hit && (data_out == head_data);
         mismatch  <= head_hit && (data_out != head_data);
         err       <= err || (head_hit && (data_out != head_data));
         proto_err <= proto_err || (push && !push_ok) || (pop && !pop_ok);
         drop      <= drop_next;
         busy      <= busy_next;
         for (int i = 0; i < NSLOT; i++) begin
            slot_data[i] <= data_next[i];
            slot_pos[i]  <= pos_next[i];
         end
      end
   end

`ifdef FORMAL
   // Valid slots must occupy distinct positions inside 1..occ.
   logic pos_inv_ok;

   always_comb begin
      pos_inv_ok = 1'b1;
      for (int i = 0; i < NSLOT; i++) begin
         if (slot_vld[i]) begin
            if ((slot_pos[i] == '0) || (slot_pos[i] > occ)) begin
               pos_inv_ok = 1'b0;
            end
            for (int j = i + 1; j < NSLOT; j++) begin
               if (slot_vld[j] && (slot_pos[j] == slot_pos[i])) begin
                  pos_inv_ok = 1'b0;
               end
            end
         end
      end
   end

   initial assume (rst);

   // Only legal strobes are considered when proving data integrity.
   always_comb begin
      assume (!push || (occ < CNTWID'(DEPTH)));
      assume (!pop || (occ != '0));
   end

   // The reset edge defines the first meaningful state.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!mismatch);
         assert (pos_inv_ok);
      end
   end
`endif

endmodule

// File: tb/tb_multi_packet_integrity_sb.sv
// ---------------------------------------------------------------------------
// tb_multi_packet_integrity_sb
//
// Testbench for multi_packet_integrity_sb. The bench plays the part of the
// monitored buffer. Its reference model is a queue of pushed words, each
// flagged as tracked or not. Expected check and drop pulses are queued
// with the cycle in which they must appear. A negedge monitor consumes
// those queues whenever the DUT pulses chk_vld or drop. Occupancy, busy
// and the sticky flags are compared after each edge.
// ---------------------------------------------------------------------------
module tb_multi_packet_integrity_sb;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 8;
   localparam int NSLOT  = 4;
   localparam int CNTWID = $clog2(DEPTH + 1);
   localparam int SLOTW  = $clog2(NSLOT + 1);

   logic              clk;
   logic              rst;
   logic              push;
   logic              pop;
   logic              start;
   logic [WIDTH-1:0]  data_in;
   logic [WIDTH-1:0]  data_out;
   logic              chk_vld;
   logic              chk_pass;
   logic              mismatch;
   logic              err;
   logic              proto_err;
   logic              drop;
   logic [CNTWID-1:0] occ;
   logic [SLOTW-1:0]  busy;

   multi_packet_integrity_sb #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .NSLOT (NSLOT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .start     (start),
      .data_in   (data_in),
      .data_out  (data_out),
      .chk_vld   (chk_vld),
      .chk_pass  (chk_pass),
      .mismatch  (mismatch),
      .err       (err),
      .proto_err (proto_err),
      .drop      (drop),
      .occ       (occ),
      .busy      (busy)
   );

   typedef struct {
      logic [WIDTH-1:0] data;
      bit               trk;
   } ent_t;

   typedef struct {
      int cyc;
      bit pass;
   } chk_t;

   ent_t fifo[$];
   chk_t expChk[$];
   int   expDrop[$];
   bit   modelErr;
   bit   modelProto;
   int   cyc;
   int   checks;
   int   failures;

   // Free-running clock and a cycle counter used to time-stamp pulses.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int trackedCount();
      int n = 0;
      foreach (fifo[i]) if (fifo[i].trk) n++;
      return n;
   endfunction

   // Registered status compared against the model after each edge.
   task automatic checkOutput();
      cmp("occ", int'(occ), fifo.size());
      cmp("busy", int'(busy), trackedCount());
      cmp("err", int'(err), int'(modelErr));
      cmp("proto_err", int'(proto_err), int'(modelProto));
   endtask

   // One clock of buffer traffic. The head word is driven on data_out
   // unless an override value is given to corrupt it.
   task automatic applyStimulus(input bit p, input bit q, input bit s,
                                input logic [WIDTH-1:0] din,
                                input bit ovr, input logic [WIDTH-1:0] ovrVal);
      bit               pushOk;
      bit               popOk;
      bit               trk;
      logic [WIDTH-1:0] dout;
      ent_t             e;
      chk_t             c;
      pushOk = p && (fifo.size() < DEPTH);
      popOk  = q && (fifo.size() > 0);
      dout   = (fifo.size() > 0) ? fifo[0].data : WIDTH'($urandom);
      if (ovr) dout = ovrVal;
      rst      = 1'b0;
      push     = p;
      pop      = q;
      start    = s;
      data_in  = din;
      data_out = dout;
      if ((p && !pushOk) || (q && !popOk)) modelProto = 1'b1;
      if (popOk) begin
         e = fifo.pop_front();
         if (e.trk) begin
            c.cyc  = cyc + 1;
            c.pass = (dout == e.data);
            expChk.push_back(c);
            if (!c.pass) modelErr = 1'b1;
         end
      end
      if (pushOk) begin
         trk = s && (trackedCount() < NSLOT);
         if (s && !trk) expDrop.push_back(cyc + 1);
         e.data = din;
         e.trk  = trk;
         fifo.push_back(e);
      end
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   // Reset with random traffic on the other inputs; reset must win.
   task automatic resetCycle();
      rst      = 1'b1;
      push     = 1'($urandom);
      pop      = 1'($urandom);
      start    = 1'($urandom);
      data_in  = WIDTH'($urandom);
      data_out = WIDTH'($urandom);
      fifo.delete();
      modelErr   = 1'b0;
      modelProto = 1'b0;
      @(posedge clk);
      #1;
      checkOutput();
      cmp("rst_chk_vld", int'(chk_vld), 0);
      cmp("rst_drop", int'(drop), 0);
   endtask

   // Monitor: consumes expected pulses whenever the DUT presents one and
   // reports pulses that came late, never came, or were not expected.
   always @(negedge clk) begin
      chk_t c;
      while (expChk.size() > 0 && expChk[0].cyc < cyc) begin
         void'(expChk.pop_front());
         cmp("chk_vld_missing", 0, 1);
      end
      while (expDrop.size() > 0 && expDrop[0] < cyc) begin
         void'(expDrop.pop_front());
         cmp("drop_missing", 0, 1);
      end
      if (chk_vld === 1'b1) begin
         if (expChk.size() > 0 && expChk[0].cyc == cyc) begin
            c = expChk.pop_front();
            cmp("chk_pass", int'(chk_pass), int'(c.pass));
            cmp("mismatch", int'(mismatch), int'(!c.pass));
         end else begin
            cmp("chk_vld_spurious", 1, 0);
         end
      end else if (mismatch === 1'b1) begin
         cmp("mismatch_without_chk", 1, 0);
      end
      if (drop === 1'b1) begin
         if (expDrop.size() > 0 && expDrop[0] == cyc) begin
            void'(expDrop.pop_front());
            cmp("drop", 1, 1 - 0 * int'(busy));
         end else begin
            cmp("drop_spurious", 1, 0);
         end
      end
   end

   initial begin
      int r;
      checks     = 0;
      failures   = 0;
      modelErr   = 1'b0;
      modelProto = 1'b0;
      rst        = 1'b1;
      push       = 1'b0;
      pop        = 1'b0;
      start      = 1'b0;
      data_in    = '0;
      data_out   = '0;
      resetCycle();

      // In-order traffic with one tracked packet at the head.
      applyStimulus(1, 0, 1, 8'h11, 0, '0);
      applyStimulus(1, 0, 0, 8'h22, 0, '0);
      applyStimulus(1, 0, 0, 8'h33, 0, '0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, '0, 0, '0);
      cmp("t1_occ_empty", int'(occ), 0);
      idle(2);

      // Three tracked packets, the middle one corrupted on exit.
      applyStimulus(1, 0, 1, 8'h5A, 0, '0);
      applyStimulus(1, 0, 1, 8'h6B, 0, '0);
      applyStimulus(1, 0, 1, 8'h7C, 0, '0);
      applyStimulus(0, 1, 0, '0, 0, '0);
      applyStimulus(0, 1, 0, '0, 1, 8'h00);
      applyStimulus(0, 1, 0, '0, 0, '0);
      idle(2);
      cmp("t2_err_sticky", int'(err), 1);

      // More start packets than slots.
      resetCycle();
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, WIDTH'(8'hA0 + i), 0, '0);
      cmp("t3_busy_full", int'(busy), NSLOT);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, '0, 0, '0);
      idle(2);

      // Retire, decrement and allocate in the same cycle.
      resetCycle();
      applyStimulus(1, 0, 1, 8'hC1, 0, '0);
      applyStimulus(1, 0, 0, 8'hC2, 0, '0);
      applyStimulus(1, 0, 0, 8'hC3, 0, '0);
      applyStimulus(1, 1, 1, 8'hC4, 0, '0);
      cmp("t4_occ_steady", int'(occ), 3);
      cmp("t4_busy_steady", int'(busy), 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, '0, 0, '0);
      idle(2);

      // Push into a full buffer with a pop, then pop an empty buffer.
      resetCycle();
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, i[0], WIDTH'(i * 7), 0, '0);
      applyStimulus(1, 1, 1, 8'hEE, 0, '0);
      cmp("t5_proto_full", int'(proto_err), 1);
      cmp("t5_occ_after_full", int'(occ), DEPTH - 1);
      for (int i = 0; i < DEPTH - 1; i++) applyStimulus(0, 1, 0, '0, 0, '0);
      applyStimulus(0, 1, 0, '0, 0, '0);
      cmp("t5_occ_empty", int'(occ), 0);
      idle(2);

      // Reset with packets in flight.
      resetCycle();
      applyStimulus(1, 0, 1, 8'h91, 1, 8'h00);
      applyStimulus(1, 0, 1, 8'h92, 0, '0);
      applyStimulus(1, 0, 1, 8'h93, 0, '0);
      resetCycle();
      cmp("t6_busy_cleared", int'(busy), 0);
      idle(3);

      // Randomised traffic, including illegal strobes and rare resets.
      for (int n = 0; n < 2000; n++) begin
         r = $urandom_range(0, 99);
         if (r == 0) begin
            resetCycle();
         end else begin
            applyStimulus(($urandom_range(0, 99) < 55),
                          ($urandom_range(0, 99) < 50),
                          ($urandom_range(0, 99) < 40),
                          WIDTH'($urandom),
                          ($urandom_range(0, 99) < 8),
                          WIDTH'($urandom));
         end
      end
      idle(4);
      cmp("pending_checks", expChk.size(), 0);
      cmp("pending_drops", expDrop.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_packet_integrity_sb.md
Name: multi_packet_integrity_sb

Overview:
Parametrised data-integrity scoreboard that watches the push/pop interface of an external in-order buffer (FIFO, DEPTH entries, first-word-fall-through data_out). It tracks up to NSLOT marked packets in flight at once, rather than a single one. For each marked packet it reports one registered pass/fail check when that packet exits. It also flags interface protocol violations. It is used as a formal/simulation checker bound alongside any FIFO-class block.

Parameters:
WIDTH, 8, data width in bits
DEPTH, 8, capacity of the monitored buffer (≥2)
NSLOT, 4, number of marked packets tracked at once (≥1)
CNTWID, $clog2(DEPTH+1), width of occupancy and slot position counters (holds 0..DEPTH)
SLOTW, $clog2(NSLOT+1), width of busy-slot count

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
push  in  1  buffer write strobe
pop  in  1  buffer read strobe
start  in  1  mark the packet pushed this cycle for tracking
data_in  in  WIDTH  buffer write data
data_out  in  WIDTH  buffer head data, valid in the cycle pop is high
chk_vld  out  1  registered pulse: a tracked packet exited last cycle
chk_pass  out  1  registered; valid with chk_vld: exiting data matched captured data
mismatch  out  1  registered pulse: chk_vld & ~chk_pass
err  out  1  sticky: any mismatch since reset
proto_err  out  1  sticky: illegal push/pop since reset
drop  out  1  registered pulse: start&push accepted but no free slot
occ  out  CNTWID  current buffer occupancy, scoreboard's model
busy  out  SLOTW  number of valid slots

Behaviour:
- Reset (rst=1 at edge): occ=0, all slots invalid, busy=0; chk_vld, chk_pass, mismatch, drop, err and proto_err all 0. Reset mid-flight discards every tracked packet with no check pulses. Reset wins over all other inputs in the same cycle.
- Legality, per cycle:
  - push_ok = push & (occ<DEPTH).
  - pop_ok = pop & (occ>0).
  - push at occ==DEPTH is illegal, even with a simultaneous pop: proto_err set, push ignored, no capture.
  - pop at occ==0 is illegal: proto_err set, pop ignored. The same-cycle push cannot be popped.
- Occupancy: occ_next = occ + push_ok − pop_ok. It never leaves 0..DEPTH.
- Each slot holds: valid, data[WIDTH], pos[CNTWID] (1 = at buffer head).
- Pop (pop_ok):
  - Every valid slot with pos≥2 decrements pos.
  - The valid slot with pos==1 (at most one exists) is retired: it goes invalid next cycle.
  - Next cycle: chk_vld=1, chk_pass=(data_out==slot.data), mismatch=~chk_pass.
  - If no slot has pos==1, there is no check pulse.
- Capture (push_ok & start):
  - Allocate the lowest-index slot that is invalid, or that is being retired this cycle.
  - Set pos=occ_next and data=data_in. The new entry sits at the tail after this cycle's pop.
  - If no slot is available: drop pulses next cycle and the packet is untracked.
  - start without push_ok: ignored.
- Simultaneous push_ok, pop_ok and capture: retire, decrement and allocate all happen in one cycle. A slot freed by retirement may be reused immediately.
- All check outputs have 1-cycle latency from the pop edge. err sets on any mismatch pulse and holds until rst.
- Invariant: valid slots have distinct pos values in 1..occ. Formal builds assert this.
- busy = popcount of valid slots, registered.
- Under FORMAL:
  - assume rst in the initial state;
  - assume ~push | occ<DEPTH;
  - assume ~pop | occ>0;
  - assert ~mismatch;
  - assert the pos invariant.

Test Plan:
1. Reset, push 0x11 with start, then push 0x22, 0x33; pop ×3 with data_out 0x11, 0x22, 0x33 → chk_vld one cycle after the first pop only, chk_pass=1, err=0, occ returns to 0.
2. Push A=0x5A (start), B=0x6B (start), C=0x7C (start); pop all, with correct data except B's data_out forced to 0x00 → three chk_vld pulses; the second has chk_pass=0 and mismatch=1; err stays 1 afterwards.
3. NSLOT=4: push 5 consecutive start packets into an empty DEPTH=8 buffer → busy=4, drop pulses once on the 5th push; popping 5 gives 4 check pulses, and the 5th pop gives none.
4. occ=3, slot at pos=1; same cycle push_ok+start+pop_ok → old slot checked, new slot allocated into index 0 with pos=3, occ stays 3, busy unchanged.
5. Fill to occ=8, then push with pop → proto_err=1, occ=7 next cycle; at occ=0, pop alone → occ stays 0, proto_err stays 1.
6. Three tracked packets in flight, assert rst for one cycle → next cycle busy=0, occ=0, err=0, proto_err=0; no chk_vld pulses for the discarded packets.
